// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scanner: hex glyph table ({g..a}, active-high)
// and sizing helper.
package sevseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Width needed to count 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to seven-segment glyph ({g,f,e,d,c,b,a}, active-high).
module hex_to_seg
  import sevseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_c
);

  assign o_seg_c = GLYPH[i_nibble];

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit seven-segment driver with frame-boundary load update.
// Optional leading-zero blanking when SEVSEG_LZB_EN is defined.
module seven_segment_mux
  import sevseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_DIV        = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] io_value,
  input  logic [NUM_DIGITS-1:0]   io_blank,
  input  logic [NUM_DIGITS-1:0]   io_dp,
  input  logic                    io_load,
  input  logic                    io_enable,
  output logic [6:0]              io_seg,
  output logic                    io_dp_out,
  output logic [NUM_DIGITS-1:0]   io_an,
  output logic                    io_pending
);

  localparam int unsigned CW = cnt_width(CLK_DIV);
  localparam int unsigned IW = cnt_width(NUM_DIGITS);
  localparam int unsigned VW = 4 * NUM_DIGITS;

  localparam logic [NUM_DIGITS-1:0] AN_PIN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_PIN_OFF = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_PIN_OFF  = SEG_ACTIVE_LOW;

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic                  r_pend;
  logic [VW-1:0]         r_sh_value;
  logic [NUM_DIGITS-1:0] r_sh_blank;
  logic [NUM_DIGITS-1:0] r_sh_dp;
  logic [VW-1:0]         r_act_value;
  logic [NUM_DIGITS-1:0] r_act_blank;
  logic [NUM_DIGITS-1:0] r_act_dp;

  logic                  w_tick;
  logic                  w_last;
  logic                  w_frame;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic                  w_pend_nxt;
  logic [VW-1:0]         w_act_value_nxt;
  logic [NUM_DIGITS-1:0] w_act_blank_nxt;
  logic [NUM_DIGITS-1:0] w_act_dp_nxt;

  logic [3:0]            w_nib;
  logic                  w_blank;
  logic                  w_dp;
  logic                  w_lzb;
  logic [NUM_DIGITS-1:0] w_an;
  logic [6:0]            w_glyph;
  logic [6:0]            w_seg_lit;

  // Scan timing and frame-boundary handoff of the shadow into the active registers
  always_comb begin
    w_tick          = io_enable && (r_cnt == CW'(CLK_DIV - 1));
    w_last          = (r_idx == IW'(NUM_DIGITS - 1));
    w_frame         = w_tick && w_last;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_pend_nxt      = r_pend;
    w_act_value_nxt = r_act_value;
    w_act_blank_nxt = r_act_blank;
    w_act_dp_nxt    = r_act_dp;

    if (io_enable) begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + CW'(1);
    end
    if (w_tick) begin
      w_idx_nxt = w_last ? '0 : r_idx + IW'(1);
    end
    if (io_load) begin
      w_pend_nxt = 1'b1;
    end
    if (w_frame) begin
      w_pend_nxt = 1'b0;
      if (io_load) begin
        w_act_value_nxt = io_value;
        w_act_blank_nxt = io_blank;
        w_act_dp_nxt    = io_dp;
      end else if (r_pend) begin
        w_act_value_nxt = r_sh_value;
        w_act_blank_nxt = r_sh_blank;
        w_act_dp_nxt    = r_sh_dp;
      end
    end
  end

  // Select the digit that will be lit after this edge
  always_comb begin
    w_nib   = '0;
    w_blank = 1'b1;
    w_dp    = 1'b0;
    w_lzb   = 1'b0;
    w_an    = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IW'(i)) begin
        w_nib   = w_act_value_nxt[4*i +: 4];
        w_blank = w_act_blank_nxt[i];
        w_dp    = w_act_dp_nxt[i];
        w_an[i] = 1'b1;
`ifdef SEVSEG_LZB_EN
        w_lzb   = (i > 0) && ((w_act_value_nxt >> (4*i)) == VW'(0));
`else
        w_lzb   = 1'b0;
`endif
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .i_nibble (w_nib),
    .o_seg_c  (w_glyph)
  );

  assign w_seg_lit  = (w_blank || w_lzb) ? SEG_OFF : w_glyph;
  assign io_pending = r_pend;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pend      <= 1'b0;
      r_sh_value  <= '0;
      r_sh_blank  <= '1;
      r_sh_dp     <= '0;
      r_act_value <= '0;
      r_act_blank <= '1;
      r_act_dp    <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_pend      <= w_pend_nxt;
      r_act_value <= w_act_value_nxt;
      r_act_blank <= w_act_blank_nxt;
      r_act_dp    <= w_act_dp_nxt;
      if (io_load) begin
        r_sh_value <= io_value;
        r_sh_blank <= io_blank;
        r_sh_dp    <= io_dp;
      end
    end
  end

  // Pin drivers with polarity applied; dark whenever the scan is disabled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_an     <= AN_PIN_OFF;
      io_seg    <= SEG_PIN_OFF;
      io_dp_out <= DP_PIN_OFF;
    end else if (io_enable) begin
      io_an     <= w_an ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      io_seg    <= w_seg_lit ^ {7{SEG_ACTIVE_LOW}};
      io_dp_out <= w_dp ^ SEG_ACTIVE_LOW;
    end else begin
      io_an     <= AN_PIN_OFF;
      io_seg    <= SEG_PIN_OFF;
      io_dp_out <= DP_PIN_OFF;
    end
  end

endmodule

// File: doc/seven_segment_mux.md
Name: seven_segment_mux

Overview:
Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display. It decodes a packed hex value per digit (0-F, full hex glyphs) and scans the digits at a programmable refresh rate. A load strobe with frame-boundary update guarantees that no frame ever shows a mix of old and new digits. It supersedes the single-digit combinational decoder; board tops instantiate it directly on the display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..16)
CLK_DIV, 1000, clock cycles each digit stays lit (>=1)
SEG_ACTIVE_LOW, 1, 1 = segment/dp pins are driven low when lit
AN_ACTIVE_LOW, 1, 1 = anode pins are driven low when selected

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
io_value  input  4*NUM_DIGITS  packed nibbles; digit i = io_value[4i+3:4i], digit 0 = rightmost
io_blank  input  NUM_DIGITS  per-digit force-blank
io_dp  input  NUM_DIGITS  per-digit decimal point
io_load  input  1  one-cycle strobe; captures io_value/io_blank/io_dp
io_enable  input  1  scan enable; low = display dark, scan frozen
io_seg  output  7  segments {g,f,e,d,c,b,a}, bit0 = a
io_dp_out  output  1  decimal point pin
io_an  output  NUM_DIGITS  one-hot digit select (after polarity)
io_pending  output  1  a load is captured but not yet displayed

Behaviour:
- State: prescaler cnt (0..CLK_DIV-1), digit index idx (0..NUM_DIGITS-1), pending shadow {value, blank, dp} plus pend flag, and active display regs {value, blank, dp}.
- tick = io_enable && cnt==CLK_DIV-1. When io_enable=1, cnt increments and wraps to 0 on tick. On tick, idx increments mod NUM_DIGITS. When io_enable=0, cnt and idx hold.
- Frame boundary = tick with idx==NUM_DIGITS-1 (idx wraps to 0).
- io_load=1: shadow <= inputs, pend <= 1. A later load before the boundary overwrites the shadow (last load wins).
- At a frame boundary with pend=1: active <= shadow, pend <= 0.
- Load coinciding with a frame boundary: active <= inputs directly (bypass), pend stays 0.
- Decode, active-high before polarity: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Outputs are registered from next-state idx and active regs. The new digit therefore appears on the pins in the same cycle that idx updates, one clock after tick.
- io_an: bit idx asserted, others inactive. io_seg = decode(active nibble[idx]); all segments off if blank[idx]. io_dp_out = dp[idx].
- io_enable=0: next cycle all io_an inactive, io_seg and io_dp_out off. On re-enable, scanning resumes at the held idx/cnt.
- Polarity: asserted level = ~X when the *_ACTIVE_LOW parameter is 1.
- Reset (async, any time): cnt=0, idx=0, pend=0, shadow and active = 0, blank = all-ones. io_an all inactive, io_seg and io_dp_out off, io_pending=0. The first digit lights on the first clock after reset release with io_enable=1.
- io_pending = pend (registered).
- CLK_DIV=1: tick every enabled cycle. Counter width is max(1, $clog2(CLK_DIV)).

Optional Feature:
SEVSEG_LZB_EN: leading-zero blanking. When defined, any digit i>0 whose active nibble and all higher nibbles are zero is blanked (dp still honoured); digit 0 is never auto-blanked. When undefined, every zero is displayed as "0". Explicit io_blank applies in both builds.

Decomposition:
- Package sevseg_pkg: the 16-entry glyph constant array (logic [6:0]) and the SEG_OFF constant.
- Sub-module hex_to_seg: purely combinational, nibble -> 7-bit glyph from the package. Instantiated once, on the selected nibble.

Test Plan (NUM_DIGITS=4, CLK_DIV=4, both polarities active-low):
- Reset asserted mid-scan -> same cycle io_an=4'hF, io_seg=7'h7F, io_dp_out=1, io_pending=0.
- Load 16'h12AF, enable -> io_pending=1 until the first boundary. Then digit0 shows io_seg=7'h0E (F) with io_an=4'b1110, advancing every 4 cycles to digits A, 2, 1.
- Active 16'h5678; load 16'h1234 while idx=2 -> digits 2,3 still show 6,5; the next frame shows 4,3,2,1; io_pending drops at the wrap.
- Load exactly on a boundary tick -> new value is shown in the next frame, io_pending never rises. Two loads in one frame -> only the second is displayed.
- io_blank=4'b0100, io_dp=4'b0001 -> digit2 io_seg=7'h7F, digit0 io_dp_out=0. Deassert io_enable at idx=1 -> all anodes off next cycle; re-enable resumes at digit1 with the remaining count.
- With SEVSEG_LZB_EN: 16'h0070 -> digits 3,2 blank, digit1 "7", digit0 "0". 16'h0000 -> only digit0 "0". Without the macro, all four digits are shown.
